// File: rtl/undriven_fill_pkg.sv
// Shared types and helpers for the undriven fill source.
package undriven_fill_pkg;

  typedef enum logic [1:0] {
    FILL_ZERO  = 2'd0,
    FILL_ONES  = 2'd1,
    FILL_CONST = 2'd2,
    FILL_LFSR  = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_t;

  localparam int LFSR_W = 16;
  // Feedback taps: bits 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Per-channel seed; an all-zero result would lock the LFSR, so it is remapped.
  function automatic logic [LFSR_W-1:0] chan_seed(input logic [LFSR_W-1:0] base, input int c);
    logic [LFSR_W-1:0] s;
    s = base ^ LFSR_W'(c + 1);
    if (s == '0) s = LFSR_W'(1);
    return s;
  endfunction

endpackage

// File: rtl/undriven_fill_lfsr.sv
// One 16-bit Fibonacci LFSR (shift left) with seed reload and step enable.
// Only the low OUT_W bits are exported; the full state stays internal.
module undriven_fill_lfsr
  import undriven_fill_pkg::*;
#(
  parameter int              OUT_W = 5,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [OUT_W-1:0] low
);

  logic [LFSR_W-1:0] state;

  // Reload wins over stepping so a fresh LFSR-mode write always starts at the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
  end

  assign low = state[OUT_W-1:0];

endmodule

// File: rtl/undriven_fill_src.sv
// Multi-channel fill source: each channel drives zero, all-ones, a
// constant or a pseudo-random value, configured by a valid/ready write port
// with an optional broadcast sweep.
// Build option: define UNDRIVEN_FILL_LFSR_EN to include the LFSR mode and its
// per-channel registers; otherwise mode 3 is stored as ZERO and step is ignored.
module undriven_fill_src
  import undriven_fill_pkg::*;
#(
  parameter int              WIDTH     = 5,
  parameter int              NCH       = 4,
  parameter logic [15:0]     LFSR_SEED = 16'hACE1,
  localparam int             CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic                 cfg_all,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [1:0]           cfg_mode,
  input  logic [WIDTH-1:0]     cfg_value,
  input  logic                 step,
  output logic [NCH*WIDTH-1:0] O,
  output logic                 busy,
  output logic                 cfg_err
);

  // Map a requested mode onto what this build can actually hold.
  function automatic mode_t store_mode(input logic [1:0] m);
`ifdef UNDRIVEN_FILL_LFSR_EN
    return mode_t'(m);
`else
    return (m == 2'd3) ? FILL_ZERO : mode_t'(m);
`endif
  endfunction

  fsm_t              state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  mode_t             lat_mode_q;
  logic [WIDTH-1:0]  lat_value_q;
  logic              cfg_err_q;

  logic              accept;
  logic              bad_ch;
  logic              last_idx;
  logic              wr_any;
  logic [CH_W-1:0]   wr_ch;
  mode_t             wr_mode;
  logic [WIDTH-1:0]  wr_value;
  logic              err_d;
  logic [NCH-1:0]    wr_sel;

  mode_t             mode_q  [NCH];
  logic [WIDTH-1:0]  value_q [NCH];

  assign accept   = cfg_valid & cfg_ready;
  assign bad_ch   = (32'(cfg_ch) >= 32'(NCH));
  assign last_idx = (idx_q == CH_W'(NCH - 1));
  assign cfg_err  = cfg_err_q;

  // FSM state register plus sweep index.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: a broadcast starts a sweep at channel 1 (channel 0 is written on accept).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept && cfg_all && (NCH > 1)) begin
          state_d = SWEEP;
          idx_d   = CH_W'(1);
        end
      end
      SWEEP: begin
        if (last_idx) state_d = IDLE;
        else          idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the port only accepts while idle.
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q == SWEEP);
  end

  // Write decode: sweep writes use the latched request, idle writes use the live port.
  always_comb begin
    wr_any   = 1'b0;
    wr_ch    = '0;
    wr_mode  = store_mode(cfg_mode);
    wr_value = cfg_value;
    err_d    = 1'b0;
    if (state_q == SWEEP) begin
      wr_any   = 1'b1;
      wr_ch    = idx_q;
      wr_mode  = lat_mode_q;
      wr_value = lat_value_q;
    end else if (accept) begin
      if (cfg_all) begin
        wr_any = 1'b1;
      end else if (bad_ch) begin
        err_d = 1'b1;
      end else begin
        wr_any = 1'b1;
        wr_ch  = cfg_ch;
      end
    end
  end

  // Latch the broadcast request for the rest of the sweep; register the error pulse.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      lat_mode_q  <= FILL_ZERO;
      lat_value_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (accept && cfg_all) begin
        lat_mode_q  <= store_mode(cfg_mode);
        lat_value_q <= cfg_value;
      end
      cfg_err_q <= err_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign wr_sel[c] = wr_any && (wr_ch == CH_W'(c));

    // Per-channel mode and constant registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
        mode_q[c]  <= FILL_ZERO;
        value_q[c] <= '0;
      end else if (wr_sel[c]) begin
        mode_q[c]  <= wr_mode;
        value_q[c] <= wr_value;
      end
    end
  end

`ifdef UNDRIVEN_FILL_LFSR_EN
  logic [WIDTH-1:0] lfsr_low [NCH];

  for (genvar c = 0; c < NCH; c++) begin : g_lfsr
    undriven_fill_lfsr #(
      .OUT_W (WIDTH),
      .SEED  (chan_seed(LFSR_SEED, c))
    ) u_lfsr (
      .clk   (CLK),
      .rst_n (ASYNCRESETN),
      .load  (wr_sel[c] && (wr_mode == FILL_LFSR)),
      .en    (step && (mode_q[c] == FILL_LFSR) && !wr_sel[c]),
      .low   (lfsr_low[c])
    );
  end
`else
  logic unused_step;
  assign unused_step = step;
`endif

  // Output decode straight from the channel registers; no output flop.
  always_comb begin
    O = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode_q[c])
        FILL_ONES:  O[c*WIDTH +: WIDTH] = '1;
        FILL_CONST: O[c*WIDTH +: WIDTH] = value_q[c];
`ifdef UNDRIVEN_FILL_LFSR_EN
        FILL_LFSR:  O[c*WIDTH +: WIDTH] = lfsr_low[c];
`endif
        default:    O[c*WIDTH +: WIDTH] = '0;
      endcase
    end
  end

endmodule
